// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep controller and the DDS register slave:
// sweep FSM states, register map and the word-advance rule.
package dds_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_RSP,
      ST_DWELL,
      ST_NEXT
   } sweep_state_e;

   localparam logic [7:0]  DDS_AMP_OFS      = 8'h00;
   localparam logic [7:0]  DDS_FREQ_OFS     = 8'h04;
   localparam logic [7:0]  DDS_MIN_OFS      = 8'h08;
   localparam logic [7:0]  DDS_PHASE_OFS    = 8'h0C;
   localparam logic [31:0] DDS_DEFAULT_FREQ = 32'd42949;

   // Next sweep point; saturates at stop so the final word is written exactly
   // and a 32-bit carry can never wrap to a small frequency.
   function automatic logic [31:0] sweep_advance(input logic [31:0] word,
                                                 input logic [31:0] step,
                                                 input logic [31:0] stop);
      logic [32:0] sum;
      sum = {1'b0, word} + {1'b0, step};
      if (sum[32] || (sum >= {1'b0, stop}))
         return stop;
      else
         return sum[31:0];
   endfunction

endpackage

// File: rtl/dds_dwell_cnt.sv
// Loadable down-counter timing the hold of each sweep point; expire_o flags
// the last cycle of the dwell.
module dds_dwell_cnt #(
   parameter int unsigned W = 24
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         expire_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// ICB-master sequencer that steps the DDS frequency register through a linear
// sweep, holding each tuning word for a programmable dwell.
module dds_sweep_ctrl
   import dds_pkg::*;
#(
   parameter logic [31:0] DDS_BASE = 32'h0,
   parameter logic [7:0]  FREQ_OFS = DDS_FREQ_OFS,
   parameter int unsigned DWELL_W  = 24,
   parameter bit          WAIT_RSP = 1'b0
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic               start,
   input  logic               stop,
   input  logic               loop_en,
   input  logic [31:0]        start_freq,
   input  logic [31:0]        stop_freq,
   input  logic [31:0]        step,
   input  logic [DWELL_W-1:0] dwell,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [31:0]        cur_freq,
   output logic               m_icb_cmd_valid,
   input  logic               m_icb_cmd_ready,
   output logic [31:0]        m_icb_cmd_addr,
   output logic               m_icb_cmd_read,
   output logic [31:0]        m_icb_cmd_wdata,
   output logic [3:0]         m_icb_cmd_wmask,
   input  logic               m_icb_rsp_valid,
   output logic               m_icb_rsp_ready,
   input  logic               m_icb_rsp_err
);

   localparam logic [31:0] FREQ_ADDR = DDS_BASE + {24'h0, FREQ_OFS};

   sweep_state_e       state_q, state_d;
   logic [31:0]        word_q, word_d;
   logic [31:0]        start_sh_q, start_sh_d;
   logic [31:0]        stop_sh_q, stop_sh_d;
   logic [31:0]        step_sh_q, step_sh_d;
   logic [DWELL_W-1:0] dwell_sh_q, dwell_sh_d;
   logic               loop_q, loop_d;
   logic               err_q, err_d;
   logic [31:0]        cur_freq_q, cur_freq_d;
   logic               stop_pend_q, stop_pend_d;

   logic               cnt_load, cnt_dec, cnt_expire;
   logic [DWELL_W-1:0] dwell_eff;
   logic               cmd_valid, rsp_ready, done_pulse;

   assign dwell_eff = (dwell_sh_q == '0) ? DWELL_W'(1) : dwell_sh_q;

   dds_dwell_cnt #(.W(DWELL_W)) u_dwell_cnt (
      .clk_i      (sys_clk),
      .rst_i      (sys_rst),
      .load_i     (cnt_load),
      .load_val_i (dwell_eff),
      .dec_i      (cnt_dec),
      .expire_o   (cnt_expire)
   );

   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      start_sh_d  = start_sh_q;
      stop_sh_d   = stop_sh_q;
      step_sh_d   = step_sh_q;
      dwell_sh_d  = dwell_sh_q;
      loop_d      = loop_q;
      err_d       = err_q;
      cur_freq_d  = cur_freq_q;
      stop_pend_d = stop_pend_q;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      cmd_valid   = 1'b0;
      rsp_ready   = 1'b0;
      done_pulse  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // A simultaneous stop suppresses the start entirely.
            if (start && !stop) begin
               start_sh_d  = start_freq;
               stop_sh_d   = stop_freq;
               step_sh_d   = step;
               dwell_sh_d  = dwell;
               loop_d      = loop_en;
               word_d      = start_freq;
               err_d       = 1'b0;
               stop_pend_d = 1'b0;
               state_d     = ST_CMD;
            end
         end

         ST_CMD: begin
            cmd_valid = 1'b1;
            if (stop)
               stop_pend_d = 1'b1;
            if (m_icb_cmd_ready) begin
               cur_freq_d = word_q;
               if (WAIT_RSP) begin
                  state_d = ST_RSP;
               end else begin
                  cnt_load = 1'b1;
                  state_d  = ST_DWELL;
               end
            end
         end

         ST_RSP: begin
            rsp_ready = 1'b1;
            if (stop)
               stop_pend_d = 1'b1;
            if (m_icb_rsp_valid) begin
               if (m_icb_rsp_err) begin
                  err_d      = 1'b1;
                  done_pulse = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  cnt_load = 1'b1;
                  state_d  = ST_DWELL;
               end
            end
         end

         ST_DWELL: begin
            cnt_dec = 1'b1;
            if (stop)
               stop_pend_d = 1'b1;
            if (stop || stop_pend_q || cnt_expire)
               state_d = ST_NEXT;
         end

         ST_NEXT: begin
            if (stop_pend_q || stop) begin
               done_pulse = 1'b1;
               state_d    = ST_IDLE;
            end else if (word_q == stop_sh_q) begin
               if (loop_q) begin
                  word_d  = start_sh_q;
                  state_d = ST_CMD;
               end else begin
                  done_pulse = 1'b1;
                  state_d    = ST_IDLE;
               end
            end else begin
               word_d  = sweep_advance(word_q, step_sh_q, stop_sh_q);
               state_d = ST_CMD;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= ST_IDLE;
         word_q      <= '0;
         start_sh_q  <= '0;
         stop_sh_q   <= '0;
         step_sh_q   <= '0;
         dwell_sh_q  <= '0;
         loop_q      <= 1'b0;
         err_q       <= 1'b0;
         cur_freq_q  <= '0;
         stop_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         start_sh_q  <= start_sh_d;
         stop_sh_q   <= stop_sh_d;
         step_sh_q   <= step_sh_d;
         dwell_sh_q  <= dwell_sh_d;
         loop_q      <= loop_d;
         err_q       <= err_d;
         cur_freq_q  <= cur_freq_d;
         stop_pend_q <= stop_pend_d;
      end
   end

   // Payload is gated by valid so the bus reads zero whenever nothing is offered.
   assign m_icb_cmd_valid = cmd_valid;
   assign m_icb_cmd_addr  = cmd_valid ? FREQ_ADDR : '0;
   assign m_icb_cmd_wdata = cmd_valid ? word_q : '0;
   assign m_icb_cmd_read  = 1'b0;
   assign m_icb_cmd_wmask = 4'hF;
   assign m_icb_rsp_ready = rsp_ready;

   assign busy     = (state_q != ST_IDLE);
   assign done     = done_pulse;
   assign err      = err_q;
   assign cur_freq = cur_freq_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed and randomized sweeps on a
// no-response instance, backpressure/error/reset scenarios on a WAIT_RSP one.
module tb_dds_sweep_ctrl;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        loop_en;
   logic [31:0] start_freq, stop_freq, step;
   logic [23:0] dwell;

   logic        start0, stop0, busy0, done0, err0, cv0, cr0, rd0, rv0, rr0, re0;
   logic [31:0] cur0, addr0, wd0;
   logic [3:0]  wm0;

   logic        start1, stop1, busy1, done1, err1, cv1, cr1, rd1, rv1, rr1, re1;
   logic [31:0] cur1, addr1, wd1;
   logic [3:0]  wm1;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [31:0] wq[$];
   logic [31:0] aq[$];
   int          cq[$];
   int          done_cnt = 0;
   int          done_cyc = 0;

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc++;

   dds_sweep_ctrl #(.WAIT_RSP(1'b0)) u0 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start0), .stop(stop0),
      .loop_en(loop_en), .start_freq(start_freq), .stop_freq(stop_freq),
      .step(step), .dwell(dwell), .busy(busy0), .done(done0), .err(err0),
      .cur_freq(cur0), .m_icb_cmd_valid(cv0), .m_icb_cmd_ready(cr0),
      .m_icb_cmd_addr(addr0), .m_icb_cmd_read(rd0), .m_icb_cmd_wdata(wd0),
      .m_icb_cmd_wmask(wm0), .m_icb_rsp_valid(rv0), .m_icb_rsp_ready(rr0),
      .m_icb_rsp_err(re0)
   );

   dds_sweep_ctrl #(.WAIT_RSP(1'b1)) u1 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start1), .stop(stop1),
      .loop_en(loop_en), .start_freq(start_freq), .stop_freq(stop_freq),
      .step(step), .dwell(dwell), .busy(busy1), .done(done1), .err(err1),
      .cur_freq(cur1), .m_icb_cmd_valid(cv1), .m_icb_cmd_ready(cr1),
      .m_icb_cmd_addr(addr1), .m_icb_cmd_read(rd1), .m_icb_cmd_wdata(wd1),
      .m_icb_cmd_wmask(wm1), .m_icb_rsp_valid(rv1), .m_icb_rsp_ready(rr1),
      .m_icb_rsp_err(re1)
   );

   // Write/done monitor for u0, sampled mid-cycle.
   always @(negedge sys_clk) begin
      if (cv0 && cr0) begin
         wq.push_back(wd0);
         aq.push_back(addr0);
         cq.push_back(cyc);
      end
      if (done0) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      checks++;
      failures++;
      $error("FAIL %s: timeout observed=no-event expected=event", tag);
   endtask

   task automatic run_sweep(input logic [31:0] s, input logic [31:0] e,
                            input logic [31:0] st, input int unsigned dw,
                            input string tag);
      logic [31:0]     expq[$];
      longint unsigned w;
      int unsigned     dwe;
      int              t0, limit, last;
      dwe = (dw == 0) ? 1 : dw;
      w = s;
      expq.push_back(s);
      while (w != e) begin
         w = w + st;
         if (w > e) w = e;
         expq.push_back(w[31:0]);
      end
      wq.delete(); aq.delete(); cq.delete();
      done_cnt = 0;
      start_freq = s; stop_freq = e; step = st; dwell = 24'(dw); loop_en = 1'b0;
      @(posedge sys_clk); #1;
      start0 = 1'b1;
      t0 = cyc;
      @(posedge sys_clk); #1;
      start0 = 1'b0;
      chk({tag, "/busy_rise"}, 32'(busy0), 32'd1);
      limit = expq.size() * int'(dwe + 2) + 20;
      for (int n = 0; n < limit; n++) begin
         if (done_cnt != 0) break;
         @(posedge sys_clk); #1;
      end
      if (done_cnt == 0) timeout({tag, "/done"});
      chk({tag, "/busy_fall"}, 32'(busy0), 32'd0);
      repeat (4) @(posedge sys_clk);
      #1;
      chk({tag, "/nwrites"}, 32'(wq.size()), 32'(expq.size()));
      for (int j = 0; j < wq.size() && j < expq.size(); j++) begin
         chk($sformatf("%s/wdata[%0d]", tag, j), wq[j], expq[j]);
         chk($sformatf("%s/addr[%0d]", tag, j), aq[j], 32'h4);
         if (j > 0)
            chk($sformatf("%s/period[%0d]", tag, j), 32'(cq[j] - cq[j-1]), 32'(dwe + 2));
      end
      if (wq.size() > 0) begin
         last = cq[wq.size() - 1];
         chk({tag, "/first_lat"}, 32'(cq[0]), 32'(t0 + 1));
         chk({tag, "/done_time"}, 32'(done_cyc), 32'(last + int'(dwe) + 1));
      end
      chk({tag, "/done_cnt"}, 32'(done_cnt), 32'd1);
      chk({tag, "/cur_freq"}, cur0, e);
      chk({tag, "/err"}, 32'(err0), 32'd0);
   endtask

   initial begin
      int stop_cyc;
      bit seen;
      sys_rst = 1'b1;
      loop_en = 1'b0; start_freq = '0; stop_freq = '0; step = '0; dwell = '0;
      start0 = 1'b0; stop0 = 1'b0; cr0 = 1'b1; rv0 = 1'b0; re0 = 1'b0;
      start1 = 1'b0; stop1 = 1'b0; cr1 = 1'b0; rv1 = 1'b0; re1 = 1'b0;
      #3;
      chk("rst/busy", 32'(busy0), 32'd0);
      chk("rst/done", 32'(done0), 32'd0);
      chk("rst/err", 32'(err0), 32'd0);
      chk("rst/cur_freq", cur0, 32'd0);
      chk("rst/cmd_valid", 32'(cv0), 32'd0);
      chk("rst/rsp_ready", 32'(rr1), 32'd0);
      chk("rst/addr", addr0, 32'd0);
      chk("rst/wdata", wd0, 32'd0);
      chk("rst/read", 32'(rd0), 32'd0);
      chk("rst/wmask", 32'(wm0), 32'hF);
      repeat (2) @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;

      run_sweep(32'd1000, 32'd1300, 32'd100, 4, "oneshot");
      run_sweep(32'd0, 32'd250, 32'd100, 0, "clamp");
      run_sweep(32'hFFFFFF00, 32'hFFFFFFFF, 32'h80, 3, "ovf");
      run_sweep(32'd777, 32'd777, 32'd5, 1, "single");
      for (int i = 0; i < 6; i++) begin
         logic [31:0] s, e, st;
         int unsigned span, dw;
         s    = $urandom;
         span = $urandom_range(0, 3000);
         st   = $urandom_range(40, 800);
         dw   = $urandom_range(0, 5);
         e    = (s > 32'hFFFFFFFF - span) ? 32'hFFFFFFFF : s + span;
         run_sweep(s, e, st, dw, $sformatf("rand%0d", i));
      end

      // Looping sweep, then stop during a dwell.
      wq.delete(); aq.delete(); cq.delete();
      done_cnt = 0;
      start_freq = 32'd10; stop_freq = 32'd20; step = 32'd10; dwell = 24'd2; loop_en = 1'b1;
      @(posedge sys_clk); #1;
      start0 = 1'b1;
      @(posedge sys_clk); #1;
      start0 = 1'b0;
      for (int n = 0; n < 200; n++) begin
         if (wq.size() >= 5) break;
         @(posedge sys_clk); #1;
      end
      stop_cyc = cyc;
      stop0 = 1'b1;
      @(posedge sys_clk); #1;
      stop0 = 1'b0;
      loop_en = 1'b0;
      repeat (10) @(posedge sys_clk);
      #1;
      chk("loop/nwrites", 32'(wq.size()), 32'd5);
      for (int j = 0; j < wq.size() && j < 5; j++) begin
         chk($sformatf("loop/wdata[%0d]", j), wq[j], (j % 2 == 0) ? 32'd10 : 32'd20);
         if (j > 0) chk($sformatf("loop/period[%0d]", j), 32'(cq[j] - cq[j-1]), 32'd4);
      end
      chk("loop/done_cnt", 32'(done_cnt), 32'd1);
      chk("loop/done_time", 32'(done_cyc), 32'(stop_cyc + 1));
      chk("loop/busy", 32'(busy0), 32'd0);

      // start and stop together in IDLE.
      wq.delete(); aq.delete(); cq.delete();
      done_cnt = 0;
      start0 = 1'b1; stop0 = 1'b1;
      @(posedge sys_clk); #1;
      start0 = 1'b0; stop0 = 1'b0;
      chk("collide/busy", 32'(busy0), 32'd0);
      repeat (3) @(posedge sys_clk);
      #1;
      chk("collide/nwrites", 32'(wq.size()), 32'd0);
      chk("collide/done_cnt", 32'(done_cnt), 32'd0);

      // Backpressure then error response on the WAIT_RSP instance.
      start_freq = 32'd100; stop_freq = 32'd300; step = 32'd100; dwell = 24'd1;
      cr1 = 1'b0;
      start1 = 1'b1;
      @(posedge sys_clk); #1;
      start1 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp/valid[%0d]", k), 32'(cv1), 32'd1);
         chk($sformatf("bp/addr[%0d]", k), addr1, 32'h4);
         chk($sformatf("bp/wdata[%0d]", k), wd1, 32'd100);
         @(posedge sys_clk); #1;
      end
      cr1 = 1'b1;
      @(posedge sys_clk); #1;
      cr1 = 1'b0;
      chk("bp/rsp_ready", 32'(rr1), 32'd1);
      chk("bp/valid_off", 32'(cv1), 32'd0);
      chk("bp/cur_freq", cur1, 32'd100);
      rv1 = 1'b1; re1 = 1'b1;
      #1;
      chk("rsperr/done", 32'(done1), 32'd1);
      @(posedge sys_clk); #1;
      rv1 = 1'b0; re1 = 1'b0;
      chk("rsperr/err", 32'(err1), 32'd1);
      chk("rsperr/busy", 32'(busy1), 32'd0);
      chk("rsperr/done_off", 32'(done1), 32'd0);
      start1 = 1'b1;
      @(posedge sys_clk); #1;
      start1 = 1'b0;
      chk("restart/err_clr", 32'(err1), 32'd0);
      chk("restart/busy", 32'(busy1), 32'd1);
      cr1 = 1'b1; rv1 = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 60; n++) begin
         if (done1) begin
            seen = 1'b1;
            break;
         end
         @(posedge sys_clk); #1;
      end
      if (!seen) timeout("restart/done");
      chk("restart/cur_freq", cur1, 32'd300);
      chk("restart/err", 32'(err1), 32'd0);
      cr1 = 1'b0; rv1 = 1'b0;
      @(posedge sys_clk); #1;
      chk("restart/busy_fall", 32'(busy1), 32'd0);

      // Asynchronous reset while a command is stalled.
      start1 = 1'b1;
      @(posedge sys_clk); #1;
      start1 = 1'b0;
      chk("arst/valid_before", 32'(cv1), 32'd1);
      #2;
      sys_rst = 1'b1;
      #1;
      chk("arst/valid", 32'(cv1), 32'd0);
      chk("arst/busy", 32'(busy1), 32'd0);
      chk("arst/addr", addr1, 32'd0);
      chk("arst/wdata", wd1, 32'd0);
      chk("arst/cur_freq", cur1, 32'd0);
      @(posedge sys_clk); #1;
      sys_rst = 1'b0;
      cr1 = 1'b1;
      repeat (3) begin
         @(posedge sys_clk); #1;
         chk("arst/no_retry", 32'(cv1), 32'd0);
      end
      cr1 = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
